mem_responder: RTL and testbench

// Word-addressed memory target answering the MiniSRC datapath's MAR/MDR memory requests.

---
 rtl/mem_responder_if.sv | 23 ++
 rtl/mem_responder.sv | 113 +++++++++++
 tb/tb_mem_responder.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Memory request/response bundle between the datapath memory port and mem_responder.
interface mem_responder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req;
    logic                  we;
    logic [31:0]           addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  ack;
    logic                  err;
    logic                  busy;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ack, err, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ack, err, busy
    );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory target with a req/ack handshake and a fixed number of wait states.
// Requests are latched on accept, held for WAIT_STATES cycles, then completed with a one-cycle ack.
module mem_responder #(
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 2
) (
    input  logic           clock,
    input  logic           nRst,
    mem_responder_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic                    we_q;
    logic [31:0]             addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    ack_q;
    logic                    err_q;
    logic                    busy_q;

    logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];

    logic                    accept;
    logic                    go_ack;
    logic                    txn_we;
    logic [31:0]             txn_addr;
    logic [DATA_WIDTH-1:0]   txn_wdata;
    logic                    txn_in_range;
    logic [ADDR_WIDTH-1:0]   txn_idx;
    logic                    mem_wr;

    // Transaction fields: with zero wait states the access completes on the accept edge,
    // so the live bus values are used there instead of the not-yet-latched copies.
    always_comb begin
        accept       = (state_q == S_IDLE) && bus.req;
        go_ack       = (accept && (WAIT_STATES == 0)) || ((state_q == S_WAIT) && (cnt_q <= 4'd1));
        txn_we       = accept ? bus.we    : we_q;
        txn_addr     = accept ? bus.addr  : addr_q;
        txn_wdata    = accept ? bus.wdata : wdata_q;
        txn_in_range = (txn_addr >> ADDR_WIDTH) == 32'd0;
        txn_idx      = txn_addr[ADDR_WIDTH-1:0];
        mem_wr       = go_ack && txn_we && txn_in_range;
    end

    // Array write on the edge entering ACK; a reset on that edge discards the write.
    always_ff @(posedge clock) begin
        if (nRst && mem_wr) begin
            mem[txn_idx] <= txn_wdata;
        end
    end

    // Handshake FSM with registered ack/err/busy/rdata.
    always_ff @(posedge clock) begin
        if (!nRst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ack_q <= go_ack;
            err_q <= go_ack && !txn_in_range;
            if (go_ack && !txn_we) begin
                rdata_q <= txn_in_range ? mem[txn_idx] : '0;
            end

            case (state_q)
                S_IDLE: begin
                    if (bus.req) begin
                        we_q    <= bus.we;
                        addr_q  <= bus.addr;
                        wdata_q <= bus.wdata;
                        cnt_q   <= 4'(WAIT_STATES);
                        busy_q  <= 1'b1;
                        state_q <= (WAIT_STATES == 0) ? S_ACK : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                    if (cnt_q <= 4'd1) begin
                        state_q <= S_ACK;
                    end
                end
                S_ACK: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ack   = ack_q;
    assign bus.err   = err_q;
    assign bus.busy  = busy_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one DUT with 2 wait states, one with 0 wait states.
module tb_mem_responder;
    logic clk;
    logic nRst;
    int   errors;
    int   checks;
    logic [31:0] last_rd [2];

    mem_responder_if #(.DATA_WIDTH(32)) bus  ();
    mem_responder_if #(.DATA_WIDTH(32)) bus0 ();

    mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_STATES(2)) u_dut (
        .clock (clk),
        .nRst  (nRst),
        .bus   (bus.slave)
    );

    mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_STATES(0)) u_dut0 (
        .clock (clk),
        .nRst  (nRst),
        .bus   (bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction on bus (sel=0, 2 wait states) or bus0 (sel=1, 0 wait states).
    task automatic txn(input bit sel, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input bit exp_err, input string tag);
        int ws;
        logic [31:0] rd;
        ws = sel ? 0 : 2;
        rd = w ? last_rd[sel] : exp_rd;
        @(negedge clk);
        if (sel) begin
            bus0.req = 1'b1; bus0.we = w; bus0.addr = a; bus0.wdata = d;
        end else begin
            bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
        end
        @(posedge clk);
        #1;
        // Inputs change after accept; the latched copies must be used.
        if (sel) begin
            bus0.req = 1'b0; bus0.we = ~w; bus0.addr = ~a; bus0.wdata = ~d;
        end else begin
            bus.req = 1'b0; bus.we = ~w; bus.addr = ~a; bus.wdata = ~d;
        end
        for (int i = 0; i < ws; i++) begin
            chk({tag, "_ack_wait"}, {31'd0, sel ? bus0.ack : bus.ack}, 32'd0);
            @(posedge clk);
            #1;
        end
        chk({tag, "_ack"},   {31'd0, sel ? bus0.ack  : bus.ack},  32'd1);
        chk({tag, "_err"},   {31'd0, sel ? bus0.err  : bus.err},  {31'd0, exp_err});
        chk({tag, "_busy"},  {31'd0, sel ? bus0.busy : bus.busy}, 32'd1);
        chk({tag, "_rdata"}, sel ? bus0.rdata : bus.rdata, rd);
        @(posedge clk);
        #1;
        chk({tag, "_ack_after"},   {31'd0, sel ? bus0.ack  : bus.ack},  32'd0);
        chk({tag, "_err_after"},   {31'd0, sel ? bus0.err  : bus.err},  32'd0);
        chk({tag, "_busy_after"},  {31'd0, sel ? bus0.busy : bus.busy}, 32'd0);
        chk({tag, "_rdata_hold"},  sel ? bus0.rdata : bus.rdata, rd);
        last_rd[sel] = rd;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        nRst = 1'b0;
        bus.req = 1'b0;  bus.we = 1'b0;  bus.addr = '0;  bus.wdata = '0;
        bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = '0; bus0.wdata = '0;

        // Reset for two cycles, then idle for ten.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack",   {31'd0, bus.ack},  32'd0);
        chk("rst_err",   {31'd0, bus.err},  32'd0);
        chk("rst_busy",  {31'd0, bus.busy}, 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst0_ack",  {31'd0, bus0.ack}, 32'd0);
        @(negedge clk);
        nRst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("idle_ack",   {31'd0, bus.ack},  32'd0);
            chk("idle_busy",  {31'd0, bus.busy}, 32'd0);
            chk("idle_rdata", bus.rdata, 32'd0);
        end

        // Write then read back.
        txn(1'b0, 1'b1, 32'h0000_0005, 32'hDEAD_BEEF, 32'h0,         1'b0, "wr05");
        txn(1'b0, 1'b0, 32'h0000_0005, 32'h0,         32'hDEAD_BEEF, 1'b0, "rd05");

        // Range check: 0x200 is out of range, 0x1FF is the top valid word.
        txn(1'b0, 1'b1, 32'h0000_0000, 32'h0BAD_F00D, 32'h0,         1'b0, "wr000");
        txn(1'b0, 1'b1, 32'h0000_0200, 32'h0000_1234, 32'h0,         1'b1, "wr200");
        txn(1'b0, 1'b0, 32'h0000_0200, 32'h0,         32'h0,         1'b1, "rd200");
        txn(1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'h0BAD_F00D, 1'b0, "rd000");
        txn(1'b0, 1'b1, 32'h8000_0000, 32'h5555_5555, 32'h0,         1'b1, "wrhigh");
        txn(1'b0, 1'b1, 32'h0000_01FF, 32'hCAFE_F00D, 32'h0,         1'b0, "wr1ff");

        // Held req: accepts at k=0,4,8; acks at k%4==2; single idle cycle at k%4==3.
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h0000_01FF; bus.wdata = '0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            chk("held_ack",  {31'd0, bus.ack},  {31'd0, (k % 4) == 2});
            chk("held_busy", {31'd0, bus.busy}, {31'd0, (k % 4) != 3});
            if ((k % 4) == 2) chk("held_rdata", bus.rdata, 32'hCAFE_F00D);
        end
        bus.req = 1'b0;
        last_rd[0] = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        chk("held_quiet", {31'd0, bus.busy}, 32'd0);

        // Reset during WAIT drops the pending write.
        txn(1'b0, 1'b1, 32'h0000_0010, 32'h1111_2222, 32'h0, 1'b0, "wr10");
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h0000_0010; bus.wdata = 32'hAAAA_5555;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        chk("mid_busy", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        nRst = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_ack",   {31'd0, bus.ack},  32'd0);
        chk("mid_busy0", {31'd0, bus.busy}, 32'd0);
        chk("mid_rdata", bus.rdata, 32'd0);
        @(negedge clk);
        nRst = 1'b1;
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("mid_noack", {31'd0, bus.ack}, 32'd0);
        end
        txn(1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'h1111_2222, 1'b0, "rd10");

        // Zero-wait-state build: ack the cycle right after accept, address change ignored.
        txn(1'b1, 1'b1, 32'h0000_0020, 32'h0000_BEEF, 32'h0,         1'b0, "z_wr20");
        txn(1'b1, 1'b1, 32'h0000_0021, 32'h1234_5678, 32'h0,         1'b0, "z_wr21");
        txn(1'b1, 1'b0, 32'h0000_0020, 32'h0,         32'h0000_BEEF, 1'b0, "z_rd20");
        txn(1'b1, 1'b0, 32'h0000_0021, 32'h0,         32'h1234_5678, 1'b0, "z_rd21");
        txn(1'b1, 1'b0, 32'h0000_0200, 32'h0,         32'h0,         1'b1, "z_rd200");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
